motor_cmd_ramp: RTL and testbench
=================================

MOTOR_CMD_RAMP -- requirements
Module: motor_cmd_ramp

Interface
REQ-001 SHALL have parameter PWM_PERIOD_FREQ_HZ, default 2000, meaning the PWM period rate and the ramp update rate in Hz.
REQ-002 SHALL have parameter CLOCK_FREQ_HZ, default 100000000, meaning the clk frequency in Hz; PERIOD_TICKS = CLOCK_FREQ_HZ/PWM_PERIOD_FREQ_HZ (50000 at defaults).
REQ-003 SHALL have parameter DEAD_PERIODS, default 4, meaning the number of zero-output PWM periods inserted before a direction change.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  drive enable (level).
REQ-007 SHALL have port cmd_valid  input  1  one-cycle strobe that loads target_on_time and target_dir.
REQ-008 SHALL have port target_on_time  input  32  requested on-time in clk cycles.
REQ-009 SHALL have port target_dir  input  1  requested direction.
REQ-010 SHALL have port step  input  16  maximum on-time change per PWM period; 0 means no ramp.
REQ-011 SHALL have port on_time_out  output  32  registered on-time fed to the PWM generator.
REQ-012 SHALL have port dir_out  output  1  registered H-bridge direction.
REQ-013 SHALL have port period_tick  output  1  one-cycle pulse at each PWM period boundary.
REQ-014 SHALL have port at_target  output  1  registered, high when the output equals the latched command.

Function
REQ-015 SHALL run a free-running period counter 0..PERIOD_TICKS-1 that wraps to 0; period_tick is high for the single cycle in which the counter equals PERIOD_TICKS-1.
REQ-016 SHALL latch the command on cmd_valid in any state, storing tgt = min(target_on_time, PERIOD_TICKS) and tgt_dir = target_dir.
REQ-017 SHALL update on_time_out, dir_out and the state only on the cycle after period_tick, except for the IDLE exits given in REQ-019 and REQ-024.
REQ-018 SHALL implement states IDLE, RUN and DEAD.
REQ-019 IDLE: on_time_out = 0; when enable = 1, next cycle sets dir_out = tgt_dir and moves to RUN.
REQ-020 RUN, per tick, effective target eff = (enable ? tgt : 0).
- If tgt_dir == dir_out or enable = 0: move on_time_out toward eff by at most step, saturating at eff (no overshoot, no underflow).
- If step = 0: on_time_out = eff directly.
REQ-021 RUN with enable = 1 and tgt_dir != dir_out, per tick:
- If on_time_out != 0: decrement on_time_out by step, saturating at 0 (step = 0 sets 0).
- If on_time_out == 0: load dead counter = DEAD_PERIODS and move to DEAD.
REQ-022 RUN with enable = 0 and on_time_out == 0 at a tick SHALL move to IDLE.
REQ-023 DEAD: on_time_out = 0 and the dead counter decrements per tick; when it reaches 0, dir_out = tgt_dir and the state returns to RUN, with ramping resuming on the next tick.
REQ-024 DEAD with enable = 0 SHALL move to IDLE on the next cycle.
REQ-025 A command that reverts direction during the ramp-down in RUN SHALL cancel the reversal; ramping resumes toward tgt without a dead interval.
REQ-026 SHALL compute all sums and differences at 33-bit width with explicit saturation; on_time_out never exceeds PERIOD_TICKS.
REQ-027 at_target = (state == RUN) && enable && (on_time_out == tgt) && (dir_out == tgt_dir); it is registered and updated every cycle.
REQ-028 dir_out SHALL never change while on_time_out != 0.

Reset
REQ-029 On reset = 1 at a clock edge, the next cycle SHALL show on_time_out = 0, dir_out = 0, period_tick = 0, at_target = 0, state IDLE, period counter = 0, tgt = 0, tgt_dir = 0 and dead counter = 0.
REQ-030 Reset SHALL take priority over cmd_valid, enable and tick, including mid-ramp and in DEAD.

Verification (bench parameters: CLOCK_FREQ_HZ = 100000, PWM_PERIOD_FREQ_HZ = 10000, giving PERIOD_TICKS = 10; DEAD_PERIODS = 4)
REQ-031 Reset with random inputs -> all outputs 0; first period_tick occurs 10 cycles after reset release, then every 10 cycles.
REQ-032 enable = 1, cmd 8/dir 0, step = 3 -> on_time_out 3, 6, 8 on successive ticks; at_target = 1 after the third tick.
REQ-033 cmd 25 with step = 0 -> on_time_out = 10 (clamped) after one tick; no overshoot.
REQ-034 At 6/dir 0, cmd 6/dir 1, step = 3 -> 3, 0, then four ticks at 0 with dir_out = 0, then dir_out = 1, then 3, 6; dir_out never toggles while on_time_out != 0.
REQ-035 Reversal cancelled: at 6/dir 0, cmd dir 1 then cmd dir 0 after the first tick -> 3, then back up to 6; DEAD is never entered.
REQ-036 enable = 0 at on_time_out 6 with step = 4 -> 2, 0, then IDLE; reset asserted mid-ramp -> outputs 0 on the next cycle.

Source files
------------

// File: rtl/motor_cmd_ramp.sv
// Slew-limited on-time/direction command for an H-bridge PWM stage.
// Direction reversals ramp to zero and hold dead periods before flipping.
module motor_cmd_ramp #(
   parameter int unsigned PWM_PERIOD_FREQ_HZ = 2000,
   parameter int unsigned CLOCK_FREQ_HZ      = 100000000,
   parameter int unsigned DEAD_PERIODS       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        cmd_valid,
   input  logic [31:0] target_on_time,
   input  logic        target_dir,
   input  logic [15:0] step,
   output logic [31:0] on_time_out,
   output logic        dir_out,
   output logic        period_tick,
   output logic        at_target
);

   localparam int unsigned PERIOD_TICKS = CLOCK_FREQ_HZ / PWM_PERIOD_FREQ_HZ;
   localparam logic [31:0] PT        = 32'(PERIOD_TICKS);
   localparam logic [31:0] LAST      = 32'(PERIOD_TICKS - 1);
   localparam logic [31:0] DEAD_INIT = 32'(DEAD_PERIODS);

   typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [31:0] tgt;
   logic        tgt_dir;
   logic [31:0] dead_cnt;

   logic        tick;
   logic [32:0] eff;
   logic [32:0] up;
   logic [32:0] dn;
   logic [31:0] ramp_next;
   logic [31:0] rev_next;

   assign tick        = (cnt == LAST);
   assign period_tick = tick;

   // All arithmetic is 33 bits so carry/borrow drive the saturation.
   always_comb begin
      eff = enable ? {1'b0, tgt} : 33'd0;
      up  = {1'b0, on_time_out} + {17'd0, step};
      dn  = {1'b0, on_time_out} - {17'd0, step};
      if (step == 16'd0)
         ramp_next = eff[31:0];
      else if ({1'b0, on_time_out} < eff)
         ramp_next = (up > eff) ? eff[31:0] : up[31:0];
      else
         ramp_next = (dn[32] || dn < eff) ? eff[31:0] : dn[31:0];
      rev_next = (step == 16'd0 || dn[32]) ? 32'd0 : dn[31:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         tgt         <= '0;
         tgt_dir     <= 1'b0;
         dead_cnt    <= '0;
         on_time_out <= '0;
         dir_out     <= 1'b0;
         at_target   <= 1'b0;
      end else begin
         cnt <= tick ? 32'd0 : cnt + 32'd1;
         if (cmd_valid) begin
            tgt     <= (target_on_time > PT) ? PT : target_on_time;
            tgt_dir <= target_dir;
         end
         at_target <= (state == RUN) && enable &&
                      (on_time_out == tgt) && (dir_out == tgt_dir);
         case (state)
            IDLE: begin
               on_time_out <= '0;
               if (enable) begin
                  dir_out <= tgt_dir;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (tick) begin
                  if (enable && tgt_dir != dir_out) begin
                     if (on_time_out != 32'd0) begin
                        on_time_out <= rev_next;
                     end else begin
                        dead_cnt <= DEAD_INIT;
                        state    <= DEAD;
                     end
                  end else begin
                     on_time_out <= ramp_next;
                     if (!enable && on_time_out == 32'd0)
                        state <= IDLE;
                  end
               end
            end
            DEAD: begin
               on_time_out <= '0;
               if (!enable) begin
                  state <= IDLE;
               end else if (tick) begin
                  if (dead_cnt <= 32'd1) begin
                     dead_cnt <= '0;
                     dir_out  <= tgt_dir;
                     state    <= RUN;
                  end else begin
                     dead_cnt <= dead_cnt - 32'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Directed bench for motor_cmd_ramp with a per-tick expectation queue.
module tb_motor_cmd_ramp;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        cmd_valid;
   logic [31:0] target_on_time;
   logic        target_dir;
   logic [15:0] step;
   logic [31:0] on_time_out;
   logic        dir_out;
   logic        period_tick;
   logic        at_target;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] on;
      logic        dir;
   } exp_t;

   exp_t sb[$];

   bit          mon_en = 1'b0;
   logic        prev_dir;
   logic [31:0] prev_on;

   motor_cmd_ramp #(
      .PWM_PERIOD_FREQ_HZ(10000),
      .CLOCK_FREQ_HZ(100000),
      .DEAD_PERIODS(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .cmd_valid(cmd_valid),
      .target_on_time(target_on_time),
      .target_dir(target_dir),
      .step(step),
      .on_time_out(on_time_out),
      .dir_out(dir_out),
      .period_tick(period_tick),
      .at_target(at_target)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(int unsigned on, bit d);
      exp_t e;
      e.on  = 32'(on);
      e.dir = d;
      sb.push_back(e);
   endtask

   task automatic run_ticks(int n);
      for (int t = 0; t < n; t++) begin
         bit seen;
         exp_t e;
         seen = 1'b0;
         for (int i = 0; i < 25 && !seen; i++) begin
            @(negedge clk);
            seen = period_tick;
         end
         if (!seen) begin
            check("tick_timeout", 32'd0, 32'd1);
         end else begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("on_time", on_time_out, e.on);
               check("dir", {31'd0, dir_out}, {31'd0, e.dir});
            end
         end
      end
   endtask

   task automatic cmd(int unsigned t, bit d);
      cmd_valid      = 1'b1;
      target_on_time = 32'(t);
      target_dir     = d;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic check_zero(string tag);
      check({tag, "_on"}, on_time_out, 32'd0);
      check({tag, "_dir"}, {31'd0, dir_out}, 32'd0);
      check({tag, "_tick"}, {31'd0, period_tick}, 32'd0);
      check({tag, "_at"}, {31'd0, at_target}, 32'd0);
   endtask

   // Direction may only flip while the output was already zero.
   always @(negedge clk) begin
      if (mon_en && dir_out !== prev_dir)
         check("dir_flip_nonzero", prev_on, 32'd0);
      prev_dir = dir_out;
      prev_on  = on_time_out;
   end

   initial begin
      reset          = 1'b1;
      enable         = 1'b0;
      cmd_valid      = 1'b0;
      target_on_time = '0;
      target_dir     = 1'b0;
      step           = '0;
      repeat (3) begin
         @(negedge clk);
         enable         = 1'($urandom);
         cmd_valid      = 1'($urandom);
         target_on_time = $urandom;
         target_dir     = 1'($urandom);
         step           = 16'($urandom);
      end
      @(negedge clk);
      check_zero("reset");
      enable         = 1'b0;
      cmd_valid      = 1'b0;
      target_on_time = '0;
      target_dir     = 1'b0;
      step           = '0;
      reset          = 1'b0;
      for (int k = 0; k < 30; k++) begin
         check("tick_cadence", {31'd0, period_tick}, (k % 10 == 9) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      mon_en = 1'b1;

      // ramp up 3, 6, 8
      step   = 16'd3;
      enable = 1'b1;
      cmd(8, 1'b0);
      push(3, 1'b0);
      push(6, 1'b0);
      run_ticks(2);
      @(posedge clk);
      #1;
      check("at_target_early", {31'd0, at_target}, 32'd0);
      push(8, 1'b0);
      run_ticks(1);
      @(posedge clk);
      #1;
      check("at_target_8", {31'd0, at_target}, 32'd1);

      // clamp to period, direct jump
      step = 16'd0;
      cmd(25, 1'b0);
      push(10, 1'b0);
      push(10, 1'b0);
      run_ticks(2);
      @(posedge clk);
      #1;
      check("at_target_clamp", {31'd0, at_target}, 32'd1);

      // reversal with dead periods
      cmd(6, 1'b0);
      push(6, 1'b0);
      run_ticks(1);
      step = 16'd3;
      cmd(6, 1'b1);
      push(3, 1'b0);
      push(0, 1'b0);
      push(0, 1'b0);
      push(0, 1'b0);
      push(0, 1'b0);
      push(0, 1'b0);
      push(0, 1'b1);
      push(3, 1'b1);
      push(6, 1'b1);
      run_ticks(9);
      @(posedge clk);
      #1;
      check("at_target_rev", {31'd0, at_target}, 32'd1);

      // reversal cancelled mid ramp-down
      cmd(6, 1'b0);
      push(3, 1'b1);
      run_ticks(1);
      cmd(6, 1'b1);
      push(6, 1'b1);
      push(6, 1'b1);
      run_ticks(2);

      // disable ramps down, then idle
      enable = 1'b0;
      step   = 16'd4;
      push(2, 1'b1);
      push(0, 1'b1);
      push(0, 1'b1);
      run_ticks(3);
      cmd(8, 1'b0);
      enable = 1'b1;
      @(posedge clk);
      #1;
      check("idle_exit_dir", {31'd0, dir_out}, 32'd0);
      check("idle_exit_on", on_time_out, 32'd0);
      push(4, 1'b0);
      push(8, 1'b0);
      run_ticks(2);

      // reset mid-ramp overrides everything
      step = 16'd1;
      cmd(2, 1'b0);
      push(7, 1'b0);
      run_ticks(1);
      repeat (2) @(posedge clk);
      #1;
      mon_en         = 1'b0;
      reset          = 1'b1;
      cmd_valid      = 1'b1;
      target_on_time = 32'd9;
      enable         = 1'b1;
      @(posedge clk);
      #1;
      check_zero("mid_reset");
      reset     = 1'b0;
      cmd_valid = 1'b0;
      enable    = 1'b0;

      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
